dlx_mem_ctrl: RTL

- Requester-side controller for the single-port 32x32 word RAM. It has synchronous write, combinational read, a 5-bit word address, and WE/DI/DO.
- Accepts byte/halfword/word loads and stores from the DLX datapath on a valid/ready request channel.
- Drives the RAM port and performs read-modify-write for sub-word stores, because the RAM has no byte enables.
- Returns load data (sign/zero extended) or a misalignment error on a valid/ready response channel.

---
 rtl/dlx_mem_pkg.sv | 28 ++
 rtl/dlx_lane_align.sv | 50 +++++
 rtl/dlx_mem_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/dlx_mem_pkg.sv
// Shared definitions for the DLX data-memory controller: size encodings,
// FSM states and the alignment rule.
package dlx_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    // Reserved size is treated as a misaligned access.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dlx_lane_align.sv
// Combinational lane steering: extracts and extends load lanes, and merges a
// sub-word store lane into the old RAM word.
module dlx_lane_align
    import dlx_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_signed,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  sh;
    logic [31:0] mask;
    logic [31:0] lane;

    always_comb begin
        sh   = '0;
        mask = '1;
        case (size)
            SZ_BYTE: begin
                sh   = BIG_ENDIAN ? {~offset, 3'b000} : {offset, 3'b000};
                mask = 32'h0000_00FF;
            end
            SZ_HALF: begin
                sh   = BIG_ENDIAN ? {~offset[1], 4'b0000} : {offset[1], 4'b0000};
                mask = 32'h0000_FFFF;
            end
            default: ;
        endcase

        lane      = (word >> sh) & mask;
        load_data = lane;
        if (is_signed) begin
            case (size)
                SZ_BYTE: load_data = {{24{lane[7]}}, lane[7:0]};
                SZ_HALF: load_data = {{16{lane[15]}}, lane[15:0]};
                default: ;
            endcase
        end

        // A full-word size leaves sh=0 and mask all-ones, so merged is just wdata.
        merged = (word & ~(mask << sh)) | ((wdata & mask) << sh);
    end

endmodule

// File: rtl/dlx_mem_ctrl.sv
// Requester-side controller for the single-port word RAM: byte/half/word
// loads and stores, read-modify-write for sub-word stores, valid/ready channels.
module dlx_mem_ctrl
    import dlx_mem_pkg::*;
#(
    parameter bit          BIG_ENDIAN = 1'b1,
    parameter int unsigned ADDR_W     = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_WE,
    output logic [31:0]       RAM_DI,
    input  logic [31:0]       RAM_DO
);

    state_t      state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        req_bad;

    dlx_lane_align #(
        .BIG_ENDIAN(BIG_ENDIAN)
    ) u_align (
        .word      (RAM_DO),
        .wdata     (wdata_q),
        .offset    (off_q),
        .size      (size_q),
        .is_signed (signed_q),
        .load_data (load_data),
        .merged    (merged)
    );

    assign req_bad   = misaligned(req_size, req_addr[1:0]);
    assign req_ready = !RST && (state == IDLE);
    assign RAM_WE    = !RST && ((state == WRITE) ||
                                (state == ACCESS && we_q && size_q == SZ_WORD));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            signed_q  <= 1'b0;
            off_q     <= '0;
            wdata_q   <= '0;
            RAM_ADDR  <= '0;
            RAM_DI    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        off_q     <= req_addr[1:0];
                        wdata_q   <= req_wdata;
                        RAM_ADDR  <= req_addr[ADDR_W+1:2];
                        rsp_rdata <= '0;
                        rsp_err   <= req_bad;
                        if (req_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state <= ACCESS;
                            // RAM_DI is registered, so a word store loads it here
                            // to have it valid during the ACCESS write cycle.
                            if (req_we && req_size == SZ_WORD)
                                RAM_DI <= req_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rsp_rdata <= load_data;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if (size_q == SZ_WORD) begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        RAM_DI <= merged;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
